// File: rtl/register_file_mp.sv
// Multi-pipe register file: NUM_PIPES write ports, NUM_PIPES*RD_PORTS registered read ports.
// Optional macro RF_BYPASS_EN forwards same-edge write data to matching reads.

module register_file_mp_rd_port #(
    parameter int NUM_REGS = 128,
    parameter int DATA_W   = 128,
    parameter int AW       = 7
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             en,
    input  logic [AW-1:0]                    addr,
    input  logic [NUM_REGS-1:0][DATA_W-1:0]  regs,
    input  logic                             fwd_hit,
    input  logic [DATA_W-1:0]                fwd_data,
    output logic                             valid,
    output logic [DATA_W-1:0]                data
);
    localparam logic [AW:0] NREGS = (AW+1)'(NUM_REGS);

    logic [DATA_W-1:0] rd_val;

    // Out-of-range addresses read as zero, even when a write targets them.
    always_comb begin
        rd_val = '0;
        if ({1'b0, addr} < NREGS) begin
            if (fwd_hit) rd_val = fwd_data;
            else         rd_val = regs[addr];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            valid <= en;
            if (en) data <= rd_val;
        end
    end
endmodule

module register_file_mp #(
    parameter int NUM_PIPES = 2,
    parameter int NUM_REGS  = 128,
    parameter int DATA_W    = 128,
    parameter int RD_PORTS  = 3,
    localparam int AW       = $clog2(NUM_REGS),
    localparam int NRD      = NUM_PIPES * RD_PORTS
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NRD-1:0]              rd_en,
    input  logic [NRD*AW-1:0]           rd_addr,
    output logic [NRD*DATA_W-1:0]       rd_data,
    output logic [NRD-1:0]              rd_valid,
    input  logic [NUM_PIPES-1:0]        wr_en,
    input  logic [NUM_PIPES*AW-1:0]     wr_addr,
    input  logic [NUM_PIPES*DATA_W-1:0] wr_data,
    output logic                        wr_conflict
);
    localparam logic [AW:0] NREGS = (AW+1)'(NUM_REGS);

    logic [NUM_REGS-1:0][DATA_W-1:0]  regs;
    logic [NRD-1:0][AW-1:0]           ra;
    logic [NRD-1:0][DATA_W-1:0]       rd;
    logic [NUM_PIPES-1:0][AW-1:0]     wa;
    logic [NUM_PIPES-1:0][DATA_W-1:0] wd;
    logic [NRD-1:0]                   fwd_hit;
    logic [NRD-1:0][DATA_W-1:0]       fwd_data;
    logic                             conflict_nxt;

    assign ra      = rd_addr;
    assign wa      = wr_addr;
    assign wd      = wr_data;
    assign rd_data = rd;

    // Ascending pipe order: the last NBA to a register wins, giving the highest pipe priority.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regs <= '0;
        end else begin
            for (int p = 0; p < NUM_PIPES; p++)
                if (wr_en[p] && ({1'b0, wa[p]} < NREGS)) regs[wa[p]] <= wd[p];
        end
    end

    always_comb begin
        conflict_nxt = 1'b0;
        for (int i = 0; i < NUM_PIPES; i++)
            for (int j = i + 1; j < NUM_PIPES; j++)
                if (wr_en[i] && wr_en[j] && (wa[i] == wa[j])) conflict_nxt = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) wr_conflict <= 1'b0;
        else        wr_conflict <= conflict_nxt;
    end

`ifdef RF_BYPASS_EN
    always_comb begin
        for (int k = 0; k < NRD; k++) begin
            fwd_hit[k]  = 1'b0;
            fwd_data[k] = '0;
            for (int p = 0; p < NUM_PIPES; p++)
                if (wr_en[p] && (wa[p] == ra[k])) begin
                    fwd_hit[k]  = 1'b1;
                    fwd_data[k] = wd[p];
                end
        end
    end
`else
    assign fwd_hit  = '0;
    assign fwd_data = '0;
`endif

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        register_file_mp_rd_port #(
            .NUM_REGS (NUM_REGS),
            .DATA_W   (DATA_W),
            .AW       (AW)
        ) u_port (
            .clk      (clk),
            .reset    (reset),
            .en       (rd_en[k]),
            .addr     (ra[k]),
            .regs     (regs),
            .fwd_hit  (fwd_hit[k]),
            .fwd_data (fwd_data[k]),
            .valid    (rd_valid[k]),
            .data     (rd[k])
        );
    end
endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: default config plus a 4-pipe/100-reg/32-bit instance.
module tb_register_file_mp;
    localparam int AW = 7;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [5:0]   rd_en;
    logic [41:0]  rd_addr;
    logic [767:0] rd_data;
    logic [5:0]   rd_valid;
    logic [1:0]   wr_en;
    logic [13:0]  wr_addr;
    logic [255:0] wr_data;
    logic         wr_conflict;

    logic [11:0]  b_rd_en;
    logic [83:0]  b_rd_addr;
    logic [383:0] b_rd_data;
    logic [11:0]  b_rd_valid;
    logic [3:0]   b_wr_en;
    logic [27:0]  b_wr_addr;
    logic [127:0] b_wr_data;
    logic         b_wr_conflict;

    int n_chk = 0;
    int n_fail = 0;

    register_file_mp dut (
        .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_valid(rd_valid), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_conflict(wr_conflict)
    );

    register_file_mp #(.NUM_PIPES(4), .NUM_REGS(100), .DATA_W(32)) dut_b (
        .clk(clk), .reset(reset), .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .rd_valid(b_rd_valid), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .wr_conflict(b_wr_conflict)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_en = '0; wr_en = '0; b_rd_en = '0; b_wr_en = '0;
    endtask

    task automatic wr(input int p, input int a, input logic [127:0] d);
        wr_en[p] = 1'b1;
        wr_addr[p*AW +: AW] = AW'(a);
        wr_data[p*128 +: 128] = d;
    endtask

    task automatic rd(input int k, input int a);
        rd_en[k] = 1'b1;
        rd_addr[k*AW +: AW] = AW'(a);
    endtask

    function automatic logic [127:0] port(input int k);
        return rd_data[k*128 +: 128];
    endfunction

    logic [127:0] v5;
    logic [127:0] byp_exp;

    initial begin
        v5 = {16'h000A, 112'h0};
        reset = 1'b0;
        rd_addr = '0; wr_addr = '0; wr_data = '0;
        b_rd_addr = '0; b_wr_addr = '0; b_wr_data = '0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rd_valid", 128'(rd_valid), 128'h0);
        chk("reset_conflict", 128'(wr_conflict), 128'h0);
        chk("reset_rd_data0", port(0), 128'h0);
        reset = 1'b1;

        // Basic write then read on pipe 1 rb; register 0 is ordinary storage.
        wr(0, 5, v5); wr(1, 0, 128'h77);
        step();
        chk("no_conflict_diff_addr", 128'(wr_conflict), 128'h0);
        chk("rd_valid_idle", 128'(rd_valid), 128'h0);
        idle(); rd(4, 5); rd(0, 0);
        step();
        chk("basic_rd_data", port(4), v5);
        chk("reg0_not_zero", port(0), 128'h77);
        chk("basic_rd_valid", 128'(rd_valid), 128'(6'b010001));
        idle();
        step();
        chk("no_en_valid_low", 128'(rd_valid), 128'h0);
        chk("no_en_data_hold", port(4), v5);

        // Collision on reg 7: pipe 1 wins, conflict pulses once.
        wr(0, 7, 128'hC); wr(1, 7, 128'hB);
        step();
        chk("conflict_high", 128'(wr_conflict), 128'h1);
        idle(); rd(0, 7);
        step();
        chk("conflict_one_cycle", 128'(wr_conflict), 128'h0);
        chk("collision_winner", port(0), 128'hB);

        // Same-edge read/write of reg 9.
        idle(); wr(0, 9, 128'hD); rd(2, 9);
        step();
`ifdef RF_BYPASS_EN
        byp_exp = 128'hD;
`else
        byp_exp = 128'h0;
`endif
        chk("bypass_same_edge", port(2), byp_exp);
        idle(); rd(2, 9);
        step();
        chk("bypass_next_read", port(2), 128'hD);

        // Broadcast read of reg 10 on all six ports.
        idle(); wr(1, 10, 128'hE);
        step();
        idle();
        for (int k = 0; k < 6; k++) rd(k, 10);
        step();
        for (int k = 0; k < 6; k++) chk($sformatf("broadcast_p%0d", k), port(k), 128'hE);
        chk("broadcast_valid", 128'(rd_valid), 128'(6'h3F));

        // Mid-operation reset with reg 5 = 0xA and conflict pending.
        idle(); wr(0, 5, 128'hA);
        step();
        idle(); rd(0, 5); wr(0, 3, 128'h1); wr(1, 3, 128'h2);
        step();
        chk("pre_reset_data", port(0), 128'hA);
        chk("pre_reset_conflict", 128'(wr_conflict), 128'h1);
        idle(); wr(0, 6, 128'h55); rd(1, 5);
        #3 reset = 1'b0;
        #1;
        chk("async_rst_data0", port(0), 128'h0);
        chk("async_rst_conflict", 128'(wr_conflict), 128'h0);
        chk("async_rst_valid", 128'(rd_valid), 128'h0);
        step();
        step();
        idle();
        reset = 1'b1;
        rd(0, 5); rd(1, 6);
        step();
        chk("post_reset_reg5", port(0), 128'h0);
        chk("post_reset_reg6_no_write", port(1), 128'h0);
        chk("post_reset_valid", 128'(rd_valid), 128'(6'b000011));

        // 4-pipe, 100-register, 32-bit instance: in-range vs out-of-range.
        idle();
        b_wr_en = 4'b1001;
        b_wr_addr[3*AW +: AW] = 7'd99;  b_wr_data[3*32 +: 32] = 32'h1234;
        b_wr_addr[0*AW +: AW] = 7'd120; b_wr_data[0*32 +: 32] = 32'hFFFF;
        step();
        idle();
        b_rd_en = 12'b0111;
        b_rd_addr[0*AW +: AW] = 7'd99;
        b_rd_addr[1*AW +: AW] = 7'd120;
        b_rd_addr[2*AW +: AW] = 7'd20;
        step();
        chk("b_reg99", 128'(b_rd_data[0*32 +: 32]), 128'h1234);
        chk("b_reg120_zero", 128'(b_rd_data[1*32 +: 32]), 128'h0);
        chk("b_reg20_untouched", 128'(b_rd_data[2*32 +: 32]), 128'h0);
        chk("b_rd_valid", 128'(b_rd_valid), 128'(12'b0111));
        idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/register_file_mp.md
REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 Parameter NUM_PIPES, default 2; number of issue pipes; each pipe has one read group and one write port.
REQ-002 Parameter NUM_REGS, default 128; number of architectural registers.
REQ-003 Parameter DATA_W, default 128; register width in bits.
REQ-004 Parameter RD_PORTS, default 3; read ports per pipe (ra, rb, rc order).
REQ-005 Derived AW = $clog2(NUM_REGS); NRD = NUM_PIPES*RD_PORTS.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 rd_en  input  NRD  per-read-port request; port p*RD_PORTS+k is pipe p, operand k.
REQ-009 rd_addr  input  NRD*AW  packed read addresses, port 0 in LSBs.
REQ-010 rd_data  output  NRD*DATA_W  packed registered read data, port 0 in LSBs.
REQ-011 rd_valid  output  NRD  high one cycle after a sampled rd_en.
REQ-012 wr_en  input  NUM_PIPES  per-pipe write-back enable.
REQ-013 wr_addr  input  NUM_PIPES*AW  packed write addresses.
REQ-014 wr_data  input  NUM_PIPES*DATA_W  packed write data.
REQ-015 wr_conflict  output  1  registered; high one cycle after any two enabled writes target the same address.

Function
REQ-016 Storage: NUM_REGS x DATA_W flops; no hardwired-zero register.
REQ-017 Read latency 1: rd_en sampled at edge N -> rd_data/rd_valid for that port valid after edge N, held until next edge.
REQ-018 Port with rd_en low at an edge: rd_valid 0, rd_data holds previous value.
REQ-019 Write: wr_en high at edge N -> register updated at edge N, visible to reads sampled at edge N+1.
REQ-020 Write collision (same address, multiple wr_en): highest pipe index wins; others discarded; wr_conflict asserted for one cycle.
REQ-021 Address >= NUM_REGS (non-power-of-2 NUM_REGS): write ignored; read returns zero with rd_valid 1.
REQ-022 Read ports independent; all NRD ports may address the same register in one cycle.
REQ-023 Same-cycle read/write, same address: behaviour set by RF_BYPASS_EN (REQ-028/029).
REQ-024 Multiple matching writes during bypass: forwarded value follows REQ-020 priority.

Reset
REQ-025 reset low: immediately (asynchronously) all registers, rd_data, rd_valid, wr_conflict cleared to zero.
REQ-026 reset low mid-operation: pending reads and writes in that cycle discarded; no write lands.
REQ-027 First edge with reset high is a normal operating edge.

Configuration
REQ-028 Macro RF_BYPASS_EN defined: read and write to same address at same edge -> rd_data returns the winning wr_data (write-through forwarding).
REQ-029 RF_BYPASS_EN undefined: same case returns pre-write register contents; new value visible from following read.

Verification
REQ-030 Reset: drive reset low mid-simulation with register 5 = 0xA -> all rd_data 0, wr_conflict 0 immediately; read reg 5 after release -> 0.
REQ-031 Basic: write reg 5 = 0x000A...0 via pipe 0, next cycle read reg 5 on pipe 1 port rb -> rd_data = 0x000A...0, rd_valid 1 one cycle after rd_en.
REQ-032 Collision: pipe 0 writes reg 7 = 0xC, pipe 1 writes reg 7 = 0xB same edge -> reg 7 = 0xB; wr_conflict 1 for one cycle.
REQ-033 Bypass: read reg 9 while pipe 0 writes reg 9 = 0xD (old 0) -> rd_data 0xD with RF_BYPASS_EN, 0 without; next read 0xD in both builds.
REQ-034 Broadcast: all six ports read reg 10 = 0xE same cycle -> all rd_data 0xE, rd_valid = 6'b111111.
REQ-035 Parameter sweep: NUM_PIPES=4, NUM_REGS=100, DATA_W=32 -> write reg 99 = 0x1234 readable; write to reg 120 ignored, read of reg 120 returns 0.
